gcn_transformation_engine: RTL and testbench

Parametrised successor to the GCN feature×weight transformation stage. It computes the product of the feature matrix (FEATURE_ROWS × FEATURE_COLS) and the weight matrix (FEATURE_COLS × WEIGHT_COLS) by fetching rows from the shared feature/weight memory over a registered read port. Results go into an internal row buffer, which the downstream aggregation (combination) stage reads by row index. Relative to the previous generation, this block adds:
- a runtime row count
- a one-cycle-latency memory port
- an addressable result buffer
- an optional saturating accumulate

---
 rtl/gcn_pkg.sv | 30 +++
 rtl/gcn_transformation_engine_if.sv | 42 ++++
 rtl/gcn_dot_product.sv | 38 +++
 rtl/gcn_transformation_engine.sv | 161 ++++++++++++++++
 tb/tb_gcn_transformation_engine.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/gcn_pkg.sv
// Shared types and defaults for the GCN feature x weight transformation engine.
package gcn_pkg;

    localparam int unsigned FeatureBaseDefault  = 512;
    localparam int unsigned InDataWidthDefault  = 5;
    localparam int unsigned DotProdWidthDefault = 16;

    typedef enum logic [2:0] {
        StIdle,
        StWRd,
        StWWait,
        StFRd,
        StFWait,
        StMac,
        StDone
    } state_e;

    typedef logic [InDataWidthDefault-1:0]  elem_t;
    typedef logic [DotProdWidthDefault-1:0] result_t;

    // Zero means "all rows"; anything larger than the buffer is clamped to it.
    function automatic int unsigned clamp_rows(input int unsigned count,
                                               input int unsigned max_rows);
        if (count == 0 || count > max_rows) begin
            return max_rows;
        end
        return count;
    endfunction

endpackage

// File: rtl/gcn_transformation_engine_if.sv
// Control, memory-port and result read-back signals of the transformation engine.
interface gcn_transformation_engine_if #(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned FEATURE_COLS   = 96,
    parameter int unsigned WEIGHT_COLS    = 3,
    parameter int unsigned IN_DATA_WIDTH  = 5,
    parameter int unsigned DOT_PROD_WIDTH = 16,
    parameter int unsigned ADDRESS_WIDTH  = 13
) ();

    logic                                    start;
    logic [$clog2(FEATURE_ROWS+1)-1:0]       row_count;
    logic [FEATURE_COLS*IN_DATA_WIDTH-1:0]   data_in;
    logic [$clog2(FEATURE_ROWS)-1:0]         read_row;
    logic                                    enable_read;
    logic [ADDRESS_WIDTH-1:0]                read_address;
    logic                                    done_trans;
    logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]   FM_WM_Row;

    modport master (
        output start,
        output row_count,
        output data_in,
        output read_row,
        input  enable_read,
        input  read_address,
        input  done_trans,
        input  FM_WM_Row
    );

    modport slave (
        input  start,
        input  row_count,
        input  data_in,
        input  read_row,
        output enable_read,
        output read_address,
        output done_trans,
        output FM_WM_Row
    );

endinterface

// File: rtl/gcn_dot_product.sv
// Combinational unsigned dot product of one feature row and one weight column.
// GCN_TRANS_SAT_EN selects saturation instead of wrap-around on overflow.
module gcn_dot_product #(
    parameter int unsigned FEATURE_COLS   = 96,
    parameter int unsigned IN_DATA_WIDTH  = 5,
    parameter int unsigned DOT_PROD_WIDTH = 16
) (
    input  logic [FEATURE_COLS*IN_DATA_WIDTH-1:0] feature,
    input  logic [FEATURE_COLS*IN_DATA_WIDTH-1:0] weight,
    output logic [DOT_PROD_WIDTH-1:0]             result
);

    localparam int unsigned FullW = 2 * IN_DATA_WIDTH + $clog2(FEATURE_COLS);

    logic [FullW-1:0] acc;

    always_comb begin
        acc = '0;
        for (int k = 0; k < int'(FEATURE_COLS); k++) begin
            acc = acc + FullW'(feature[k*IN_DATA_WIDTH +: IN_DATA_WIDTH])
                      * FullW'(weight[k*IN_DATA_WIDTH +: IN_DATA_WIDTH]);
        end
    end

`ifdef GCN_TRANS_SAT_EN
    always_comb begin
        result = acc[DOT_PROD_WIDTH-1:0];
        if (|acc[FullW-1:DOT_PROD_WIDTH]) begin
            result = '1;
        end
    end
`else
    logic unused_acc_hi;
    assign unused_acc_hi = ^acc[FullW-1:DOT_PROD_WIDTH];
    assign result = acc[DOT_PROD_WIDTH-1:0];
`endif

endmodule

// File: rtl/gcn_transformation_engine.sv
// Feature x weight transformation stage: fetches weights then feature rows, fills an
// addressable result buffer. GCN_TRANS_SAT_EN enables saturating results.
module gcn_transformation_engine
    import gcn_pkg::*;
#(
    parameter int unsigned FEATURE_ROWS   = 6,
    parameter int unsigned FEATURE_COLS   = 96,
    parameter int unsigned WEIGHT_COLS    = 3,
    parameter int unsigned IN_DATA_WIDTH  = InDataWidthDefault,
    parameter int unsigned DOT_PROD_WIDTH = DotProdWidthDefault,
    parameter int unsigned ADDRESS_WIDTH  = 13,
    parameter int unsigned FEATURE_BASE   = FeatureBaseDefault
) (
    input logic                         clk,
    input logic                         reset,
    gcn_transformation_engine_if.slave  bus
);

    localparam int unsigned RowW  = (FEATURE_ROWS > 1) ? $clog2(FEATURE_ROWS) : 1;
    localparam int unsigned CntW  = $clog2(FEATURE_ROWS + 1);
    localparam int unsigned ColW  = (WEIGHT_COLS > 1) ? $clog2(WEIGHT_COLS) : 1;
    localparam int unsigned VecW  = FEATURE_COLS * IN_DATA_WIDTH;
    localparam logic [ColW-1:0] LastCol = ColW'(WEIGHT_COLS - 1);

    state_e                    state_q, state_d;
    logic [ColW-1:0]           col_q, col_d;
    logic [RowW-1:0]           row_q, row_d;
    logic [CntW-1:0]           rows_q, rows_d;
    logic [ADDRESS_WIDTH-1:0]  addr_q, addr_d;
    logic                      rd_en;
    logic                      mac_en;
    logic                      wvalid_q;
    logic [ColW-1:0]           waddr_q;
    logic                      done_q;
    logic [VecW-1:0]           feature_q;
    logic [VecW-1:0]           weight_q [WEIGHT_COLS];
    logic [DOT_PROD_WIDTH-1:0] res_buf_q [FEATURE_ROWS][WEIGHT_COLS];
    logic [DOT_PROD_WIDTH-1:0] dot;

    gcn_dot_product #(
        .FEATURE_COLS   (FEATURE_COLS),
        .IN_DATA_WIDTH  (IN_DATA_WIDTH),
        .DOT_PROD_WIDTH (DOT_PROD_WIDTH)
    ) u_dot (
        .feature (feature_q),
        .weight  (weight_q[col_q]),
        .result  (dot)
    );

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        rows_d  = rows_q;
        addr_d  = addr_q;
        rd_en   = 1'b0;
        mac_en  = 1'b0;
        case (state_q)
            StIdle: begin
                if (bus.start) begin
                    rows_d  = CntW'(clamp_rows(32'(bus.row_count), FEATURE_ROWS));
                    col_d   = '0;
                    row_d   = '0;
                    state_d = StWRd;
                end
            end
            StWRd: begin
                rd_en  = 1'b1;
                addr_d = ADDRESS_WIDTH'(col_q);
                if (col_q == LastCol) begin
                    col_d   = '0;
                    state_d = StWWait;
                end else begin
                    col_d = col_q + ColW'(1);
                end
            end
            StWWait: state_d = StFRd;
            StFRd: begin
                rd_en   = 1'b1;
                addr_d  = ADDRESS_WIDTH'(FEATURE_BASE) + ADDRESS_WIDTH'(row_q);
                state_d = StFWait;
            end
            StFWait: state_d = StMac;
            StMac: begin
                mac_en = 1'b1;
                if (col_q == LastCol) begin
                    col_d = '0;
                    if (CntW'(row_q) + CntW'(1) == rows_q) begin
                        state_d = StDone;
                    end else begin
                        row_d   = row_q + RowW'(1);
                        state_d = StFRd;
                    end
                end else begin
                    col_d = col_q + ColW'(1);
                end
            end
            StDone: begin
                if (!bus.start) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            col_q     <= '0;
            row_q     <= '0;
            rows_q    <= '0;
            addr_q    <= '0;
            wvalid_q  <= 1'b0;
            waddr_q   <= '0;
            done_q    <= 1'b0;
            feature_q <= '0;
            for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
                weight_q[c] <= '0;
            end
            for (int r = 0; r < int'(FEATURE_ROWS); r++) begin
                for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
                    res_buf_q[r][c] <= '0;
                end
            end
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            rows_q   <= rows_d;
            addr_q   <= addr_d;
            // Weight reads return a cycle later; remember which column is in flight.
            wvalid_q <= rd_en && (state_q == StWRd);
            waddr_q  <= col_q;
            done_q   <= (state_q == StDone) && bus.start;
            if (wvalid_q) begin
                weight_q[waddr_q] <= bus.data_in;
            end
            if (state_q == StFWait) begin
                feature_q <= bus.data_in;
            end
            if (mac_en) begin
                res_buf_q[row_q][col_q] <= dot;
            end
        end
    end

    assign bus.enable_read  = rd_en;
    assign bus.read_address = addr_d;
    assign bus.done_trans   = done_q;

    always_comb begin
        bus.FM_WM_Row = '0;
        if (32'(bus.read_row) < FEATURE_ROWS) begin
            for (int c = 0; c < int'(WEIGHT_COLS); c++) begin
                bus.FM_WM_Row[c*DOT_PROD_WIDTH +: DOT_PROD_WIDTH] = res_buf_q[bus.read_row][c];
            end
        end
    end

endmodule

// File: tb/tb_gcn_transformation_engine.sv
// Directed bench for gcn_transformation_engine with a one-cycle-latency memory model.
module tb_gcn_transformation_engine;

    localparam int FR = 6;
    localparam int FC = 96;
    localparam int WC = 3;
    localparam int IW = 5;
    localparam int DW = 16;
    localparam int AW = 13;
    localparam int FB = 512;

    typedef struct {
        logic [2:0]       row;
        logic [WC*DW-1:0] exp;
    } rd_vec_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [FC*IW-1:0] feat_mem [FR];
    logic [FC*IW-1:0] wt_mem [WC];
    logic [AW-1:0]    trace [$];
    rd_vec_t          vecs [8];

    gcn_transformation_engine_if #(
        .FEATURE_ROWS(FR), .FEATURE_COLS(FC), .WEIGHT_COLS(WC),
        .IN_DATA_WIDTH(IW), .DOT_PROD_WIDTH(DW), .ADDRESS_WIDTH(AW)
    ) bus ();

    gcn_transformation_engine #(
        .FEATURE_ROWS(FR), .FEATURE_COLS(FC), .WEIGHT_COLS(WC),
        .IN_DATA_WIDTH(IW), .DOT_PROD_WIDTH(DW), .ADDRESS_WIDTH(AW), .FEATURE_BASE(FB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [FC*IW-1:0] mem_read(input logic [AW-1:0] a);
        if (int'(a) < WC) return wt_mem[a];
        if (int'(a) >= FB && int'(a) < FB + FR) return feat_mem[int'(a) - FB];
        return '0;
    endfunction

    always @(posedge clk) begin
        if (bus.enable_read) begin
            bus.data_in <= mem_read(bus.read_address);
            trace.push_back(bus.read_address);
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    function automatic logic [FC*IW-1:0] fill(input int v);
        logic [FC*IW-1:0] x;
        for (int k = 0; k < FC; k++) x[k*IW +: IW] = IW'(v);
        return x;
    endfunction

    function automatic logic [WC*DW-1:0] row3(input int c0, input int c1, input int c2);
        return {DW'(c2), DW'(c1), DW'(c0)};
    endfunction

    task automatic set_ones();
        for (int r = 0; r < FR; r++) feat_mem[r] = fill(1);
        for (int c = 0; c < WC; c++) wt_mem[c] = fill(1);
    endtask

    task automatic set_pattern();
        for (int r = 0; r < FR; r++) feat_mem[r] = fill(r);
        for (int c = 0; c < WC; c++) wt_mem[c] = fill(c + 1);
    endtask

    task automatic check_row(input int r, input logic [WC*DW-1:0] exp, input string tag);
        @(negedge clk);
        bus.read_row = 3'(r);
        #1;
        check($sformatf("%s_row%0d", tag, r), 64'(bus.FM_WM_Row), 64'(exp));
    endtask

    // Full run: start, latency to done_trans, start held in DONE, then release.
    task automatic run(input int rc, input int exp_lat, input string tag);
        int n;
        int sz;
        bit seen;
        @(negedge clk);
        bus.start = 1'b1;
        bus.row_count = 3'(rc);
        @(posedge clk);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge clk);
            n++;
            #1;
            if (bus.done_trans) seen = 1'b1;
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_lat));
        sz = trace.size();
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done_held"}, 64'(bus.done_trans), 64'd1);
        check({tag, "_no_reads_in_done"}, 64'(trace.size()), 64'(sz));
        @(negedge clk);
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        check({tag, "_done_dropped"}, 64'(bus.done_trans), 64'd0);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.row_count = '0;
        bus.read_row = '0;
        set_ones();
        repeat (2) @(negedge clk);
        #1;
        check("rst_enable_read", 64'(bus.enable_read), 64'd0);
        check("rst_read_address", 64'(bus.read_address), 64'd0);
        check("rst_done_trans", 64'(bus.done_trans), 64'd0);
        check("rst_fm_wm_row", 64'(bus.FM_WM_Row), 64'd0);
        @(negedge clk);
        reset = 1'b1;

        // All ones, six rows.
        run(6, 35, "ones");
        for (int r = 0; r < FR; r++) check_row(r, row3(96, 96, 96), "ones");

        // Feature r times weight c+1; row_count 0 means all rows.
        vecs[0] = '{3'd0, row3(0, 0, 0)};
        vecs[1] = '{3'd1, row3(96, 192, 288)};
        vecs[2] = '{3'd2, row3(192, 384, 576)};
        vecs[3] = '{3'd3, row3(288, 576, 864)};
        vecs[4] = '{3'd4, row3(384, 768, 1152)};
        vecs[5] = '{3'd5, row3(480, 960, 1440)};
        vecs[6] = '{3'd6, row3(0, 0, 0)};
        vecs[7] = '{3'd7, row3(0, 0, 0)};
        set_pattern();
        run(0, 35, "pattern");
        for (int i = 0; i < 8; i++) check_row(int'(vecs[i].row), vecs[i].exp, "pattern");

        // All elements 31 overflow; row_count 7 clamps to 6.
        for (int r = 0; r < FR; r++) feat_mem[r] = fill(31);
        for (int c = 0; c < WC; c++) wt_mem[c] = fill(31);
        run(7, 35, "max");
`ifdef GCN_TRANS_SAT_EN
        check_row(0, row3(65535, 65535, 65535), "max");
        check_row(5, row3(65535, 65535, 65535), "max");
`else
        check_row(0, row3(26720, 26720, 26720), "max");
        check_row(5, row3(26720, 26720, 26720), "max");
`endif

        // Two rows from a clean buffer, with the read address trace.
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        set_pattern();
        trace.delete();
        run(2, 15, "two");
        check("two_trace_len", 64'(trace.size()), 64'd5);
        if (trace.size() == 5) begin
            check("two_trace0", 64'(trace[0]), 64'd0);
            check("two_trace1", 64'(trace[1]), 64'd1);
            check("two_trace2", 64'(trace[2]), 64'd2);
            check("two_trace3", 64'(trace[3]), 64'd512);
            check("two_trace4", 64'(trace[4]), 64'd513);
        end
        check_row(0, row3(0, 0, 0), "two");
        check_row(1, row3(96, 192, 288), "two");
        for (int r = 2; r < FR; r++) check_row(r, row3(0, 0, 0), "two");

        // Reset during the MAC phase of row 3, then a clean one-row run.
        set_ones();
        @(negedge clk);
        bus.start = 1'b1;
        bus.row_count = 3'd6;
        bus.read_row = 3'd0;
        @(posedge clk);
        repeat (22) @(posedge clk);
        #2;
        check("mid_pre_row0", 64'(bus.FM_WM_Row), 64'(row3(96, 96, 96)));
        reset = 1'b0;
        bus.start = 1'b0;
        #1;
        check("mid_enable_read", 64'(bus.enable_read), 64'd0);
        check("mid_read_address", 64'(bus.read_address), 64'd0);
        check("mid_done_trans", 64'(bus.done_trans), 64'd0);
        check("mid_row0_cleared", 64'(bus.FM_WM_Row), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        run(1, 10, "after");
        check_row(0, row3(96, 96, 96), "after");
        check_row(1, row3(0, 0, 0), "after");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
